// File: rtl/axis_addr_slave_pkg.sv
// Shared definitions for the AXI address-channel responder.
// Holds the one-hot FSM state indices/encoding and the byte-to-word shift helper.
// Imported by axis_addr_slave; no logic of its own.
package axis_addr_slave_pkg;

    localparam int IDLE_IDX = 0;
    localparam int LOAD_IDX = 1;
    localparam int BEAT_IDX = 2;

    // One-hot: each state owns exactly one bit at its index.
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_LOAD = 3'b010,
        S_BEAT = 3'b100
    } state_t;

    // log2 of the number of bytes in one data word.
    function automatic int word_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/fifo_simple.sv
// Generic synchronous FIFO, 2^ADDR_WIDTH entries, registered read data.
// Latency: rd_dat valid the cycle after rd_en; full/empty reflect state after the last edge.
// Backpressure: writes when full and reads when empty are ignored.
//
// Ports: clk, rst (sync, active-high); wr_en/wr_dat push; rd_en pops into rd_dat;
//        full/empty status flags.
module fifo_simple #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_dat,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_dat <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_dat <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_addr_slave.sv
// AXI address-channel responder: queues burst commands and expands each into per-beat word addresses.
// Latency: command accepted at cycle T into an idle block yields first mem_val at T+3; 2-cycle gap between bursts.
// Backpressure: axi_aready drops while the 16-entry command FIFO is full; mem_rdy low holds the current beat.
//
// Ports: clk, rst (sync, active-high); axi_aaddr/axi_alen/axi_avalid/axi_aready command channel;
//        mem_addr/mem_last/mem_val/mem_rdy beat channel; busy = work queued or in flight.
// Optional: define AXIS_ADDR_SLAVE_STATS_EN to add stat_bursts/stat_beats handshake counters.
module axis_addr_slave
    import axis_addr_slave_pkg::*;
#(
    parameter int BUF_AWIDTH     = 4,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int MEM_AWIDTH     = AXI_ADDR_WIDTH - 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_aaddr,
    input  logic [AXI_LEN_WIDTH-1:0]  axi_alen,
    input  logic                      axi_avalid,
    output logic                      axi_aready,
    output logic [MEM_AWIDTH-1:0]     mem_addr,
    output logic                      mem_last,
    output logic                      mem_val,
    input  logic                      mem_rdy,
    output logic                      busy
`ifdef AXIS_ADDR_SLAVE_STATS_EN
    ,
    output logic [31:0]               stat_bursts,
    output logic [31:0]               stat_beats
`endif
);

    localparam int WORD_SHIFT = word_shift(AXI_DATA_WIDTH);
    localparam int CMD_W      = AXI_ADDR_WIDTH + AXI_LEN_WIDTH;

    state_t                    state;
    state_t                    state_nxt;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic [CMD_W-1:0]          push_dat;
    logic [CMD_W-1:0]          pop_dat;
    logic [AXI_ADDR_WIDTH-1:0] cmd_aaddr;
    logic [AXI_LEN_WIDTH-1:0]  cmd_alen;
    logic [MEM_AWIDTH-1:0]     word_addr;
    logic [AXI_LEN_WIDTH-1:0]  beat_cnt;
    logic                      beat_done;
    logic                      unused_low_bits;

    assign axi_aready = ~fifo_full & ~rst;
    assign push       = axi_avalid & axi_aready;
    assign push_dat   = {axi_aaddr, axi_alen};

    fifo_simple #(
        .DATA_WIDTH (CMD_W),
        .ADDR_WIDTH (BUF_AWIDTH)
    ) u_cmd_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_dat (push_dat),
        .rd_en  (pop),
        .rd_dat (pop_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign cmd_aaddr = pop_dat[CMD_W-1 -: AXI_ADDR_WIDTH];
    assign cmd_alen  = pop_dat[AXI_LEN_WIDTH-1:0];

    // Sub-word byte offset is dropped: unaligned starts are truncated to their word.
    assign unused_low_bits = ^cmd_aaddr[WORD_SHIFT-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: state_nxt = S_BEAT;
            S_BEAT: begin
                if (mem_rdy && (beat_cnt == '0)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Burst cursor: loaded from the popped command, advanced on each accepted non-final beat.
    // Address increments wrap naturally at 2^MEM_AWIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_addr <= '0;
            beat_cnt  <= '0;
        end else if (state[LOAD_IDX]) begin
            word_addr <= cmd_aaddr[WORD_SHIFT +: MEM_AWIDTH];
            beat_cnt  <= cmd_alen;
        end else if (state[BEAT_IDX] && mem_rdy && (beat_cnt != '0)) begin
            word_addr <= word_addr + 1'b1;
            beat_cnt  <= beat_cnt - 1'b1;
        end
    end

    assign mem_val   = state[BEAT_IDX];
    assign mem_last  = state[BEAT_IDX] & (beat_cnt == '0);
    assign mem_addr  = word_addr;
    assign busy      = ~fifo_empty | ~state[IDLE_IDX];
    assign beat_done = mem_val & mem_rdy;

`ifdef AXIS_ADDR_SLAVE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bursts <= '0;
            stat_beats  <= '0;
        end else if (beat_done) begin
            stat_beats <= stat_beats + 32'd1;
            if (mem_last) begin
                stat_bursts <= stat_bursts + 32'd1;
            end
        end
    end
`else
    // Counters compiled out; beat_done has no consumer in this build.
    logic unused_beat_done;
    assign unused_beat_done = beat_done;
`endif

endmodule
